// File: rtl/mem_ctrl_pkg.sv
// Shared types and byte-lane helpers for the byte-serial memory controller.
// Widths, FSM states and client tags live here so the top stays purely behavioural.
package mem_ctrl_pkg;

  localparam int RAM_W  = 8;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_width_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_XFER = 2'b01,
    MEM_DONE = 2'b10
  } mem_state_e;

  typedef enum logic {
    CLI_INST = 1'b0,
    CLI_DATA = 1'b1
  } mem_client_e;

  // Number of bytes moved for a data access; the unused code 3 behaves as a word.
  function automatic logic [CNT_W-1:0] byte_count(input logic [1:0] width);
    logic [CNT_W-1:0] n;
    case (width)
      MEM_BYTE: n = 3'd1;
      MEM_HALF: n = 3'd2;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [RAM_W-1:0] get_lane(input logic [WORD_W-1:0] w,
                                                input logic [1:0] k);
    logic [RAM_W-1:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [WORD_W-1:0] put_lane(input logic [WORD_W-1:0] w,
                                                 input logic [1:0] k,
                                                 input logic [RAM_W-1:0] b);
    logic [WORD_W-1:0] r;
    r = w;
    case (k)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serialises instruction fetches and data loads/stores onto a byte-wide RAM,
// little-endian, with data requests taking priority over fetches.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_needed,
  input  logic [ADDR_WIDTH-1:0] inst_addr_i,
  output logic                  inst_available_o,
  output logic [WORD_W-1:0]     inst_o,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [1:0]            dm_width,
  input  logic [WORD_W-1:0]     dm_wdata,
  output logic                  dm_valid_o,
  output logic [WORD_W-1:0]     dm_rdata_o,
  input  logic [RAM_W-1:0]      mem_din,
  output logic [RAM_W-1:0]      mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  mem_state_e              state_r;
  mem_client_e             client_r;
  logic                    we_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [CNT_W-1:0]        n_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [WORD_W-1:0]       wdata_r;
  logic [WORD_W-1:0]       asm_r;

  logic [CNT_W-1:0]        cnt_next_s;
  logic [ADDR_WIDTH-1:0]   addr_next_s;
  logic [WORD_W-1:0]       asm_next_s;

  // Next byte offset/address and the assembly word including this cycle's RAM byte.
  always_comb begin
    cnt_next_s  = cnt_r + 3'd1;
    addr_next_s = base_r + {{(ADDR_WIDTH-CNT_W){1'b0}}, cnt_next_s};
    asm_next_s  = asm_r;
    if (cnt_r != 3'd0) begin
      // Read data lags its address by one cycle, so offset cnt-1 arrives now.
      asm_next_s = put_lane(asm_r, cnt_r[1:0] - 2'd1, mem_din);
    end else begin
      asm_next_s = asm_r;
    end
  end

  // Request arbitration, byte sequencing and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= MEM_IDLE;
      client_r         <= CLI_INST;
      we_r             <= 1'b0;
      base_r           <= {ADDR_WIDTH{1'b0}};
      n_r              <= 3'd0;
      cnt_r            <= 3'd0;
      wdata_r          <= 32'h0000_0000;
      asm_r            <= 32'h0000_0000;
      inst_available_o <= 1'b0;
      inst_o           <= 32'h0000_0000;
      dm_valid_o       <= 1'b0;
      dm_rdata_o       <= 32'h0000_0000;
      mem_dout         <= 8'h00;
      mem_a            <= {ADDR_WIDTH{1'b0}};
      mem_wr           <= 1'b0;
    end else begin
      inst_available_o <= 1'b0;
      dm_valid_o       <= 1'b0;
      case (state_r)
        MEM_IDLE: begin
          cnt_r <= 3'd0;
          asm_r <= 32'h0000_0000;
          if (dm_req) begin
            client_r <= CLI_DATA;
            we_r     <= dm_we;
            base_r   <= dm_addr;
            n_r      <= byte_count(dm_width);
            wdata_r  <= dm_wdata;
            mem_a    <= dm_addr;
            mem_wr   <= dm_we;
            mem_dout <= dm_we ? dm_wdata[7:0] : 8'h00;
            state_r  <= MEM_XFER;
          end else if (inst_needed) begin
            client_r <= CLI_INST;
            we_r     <= 1'b0;
            base_r   <= inst_addr_i;
            n_r      <= 3'd4;
            wdata_r  <= 32'h0000_0000;
            mem_a    <= inst_addr_i;
            mem_wr   <= 1'b0;
            mem_dout <= 8'h00;
            state_r  <= MEM_XFER;
          end else begin
            mem_a    <= {ADDR_WIDTH{1'b0}};
            mem_wr   <= 1'b0;
            mem_dout <= 8'h00;
            state_r  <= MEM_IDLE;
          end
        end

        MEM_XFER: begin
          cnt_r <= cnt_next_s;
          if (we_r) begin
            if (cnt_next_s == n_r) begin
              mem_a      <= {ADDR_WIDTH{1'b0}};
              mem_wr     <= 1'b0;
              mem_dout   <= 8'h00;
              dm_valid_o <= 1'b1;
              state_r    <= MEM_DONE;
            end else begin
              mem_a    <= addr_next_s;
              mem_wr   <= 1'b1;
              mem_dout <= get_lane(wdata_r, cnt_next_s[1:0]);
              state_r  <= MEM_XFER;
            end
          end else begin
            asm_r    <= asm_next_s;
            mem_wr   <= 1'b0;
            mem_dout <= 8'h00;
            // Reads need one extra capture-only cycle after the last address.
            if (cnt_r == n_r) begin
              mem_a   <= {ADDR_WIDTH{1'b0}};
              state_r <= MEM_DONE;
              if (client_r == CLI_DATA) begin
                dm_rdata_o <= asm_next_s;
                dm_valid_o <= 1'b1;
              end else begin
                inst_o           <= asm_next_s;
                inst_available_o <= 1'b1;
              end
            end else if (cnt_next_s < n_r) begin
              mem_a   <= addr_next_s;
              state_r <= MEM_XFER;
            end else begin
              mem_a   <= {ADDR_WIDTH{1'b0}};
              state_r <= MEM_XFER;
            end
          end
        end

        MEM_DONE: begin
          cnt_r    <= 3'd0;
          mem_a    <= {ADDR_WIDTH{1'b0}};
          mem_wr   <= 1'b0;
          mem_dout <= 8'h00;
          state_r  <= MEM_IDLE;
        end

        default: begin
          cnt_r    <= 3'd0;
          mem_a    <= {ADDR_WIDTH{1'b0}};
          mem_wr   <= 1'b0;
          mem_dout <= 8'h00;
          state_r  <= MEM_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a 4 KiB byte RAM model and per-client
// expected-result queues popped whenever a valid pulse is observed.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        inst_needed;
  logic [31:0] inst_addr_i;
  logic        inst_available_o;
  logic [31:0] inst_o;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [1:0]  dm_width;
  logic [31:0] dm_wdata;
  logic        dm_valid_o;
  logic [31:0] dm_rdata_o;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic        pl_we;
  logic [11:0] pl_a;
  logic [7:0]  pl_d;
  logic [7:0]  ram [0:4095];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int inst_cnt = 0;
  int dm_cnt = 0;
  int inst_cyc = 0;
  int dm_cyc = 0;
  int acc = 0;
  logic [31:0] inst_q [$];
  logic [32:0] dm_q [$];

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .inst_needed(inst_needed), .inst_addr_i(inst_addr_i),
    .inst_available_o(inst_available_o), .inst_o(inst_o),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_width(dm_width),
    .dm_wdata(dm_wdata), .dm_valid_o(dm_valid_o), .dm_rdata_o(dm_rdata_o),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: write at the edge, read data appears the cycle after the address.
  always @(posedge clk) begin
    if (pl_we) ram[pl_a] <= pl_d;
    else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [32:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (inst_available_o === 1'b1) begin
      inst_cnt++;
      inst_cyc = cyc;
      check("inst_pending", (inst_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (inst_q.size() > 0) check("inst_o", inst_o, inst_q.pop_front());
    end
    if (dm_valid_o === 1'b1) begin
      dm_cnt++;
      dm_cyc = cyc;
      check("dm_pending", (dm_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (dm_q.size() > 0) begin
        e = dm_q.pop_front();
        if (e[32]) check("dm_rdata_o", dm_rdata_o, e[31:0]);
      end
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pl_we = 1'b1;
    pl_a = a;
    pl_d = d;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic wait_valid(input bit for_inst, input int maxc);
    int start;
    int n;
    start = for_inst ? inst_cnt : dm_cnt;
    n = 0;
    while (((for_inst ? inst_cnt : dm_cnt) == start) && (n < maxc)) begin
      tick();
      n++;
    end
    check(for_inst ? "inst_timeout" : "dm_timeout",
          ((for_inst ? inst_cnt : dm_cnt) != start) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; inst_needed = 1'b0; inst_addr_i = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = 32'h0; dm_width = 2'd0; dm_wdata = 32'h0; pl_we = 1'b0; pl_a = 12'h0; pl_d = 8'h0;
    tick(); tick();
    preload(12'h100, 8'h13); preload(12'h101, 8'h05); preload(12'h102, 8'h50); preload(12'h103, 8'h00);
    preload(12'h201, 8'h00); preload(12'h202, 8'h00); preload(12'h203, 8'h77); preload(12'h204, 8'h99);
    preload(12'h300, 8'h00); preload(12'h301, 8'h00); preload(12'h302, 8'h00); preload(12'h303, 8'h00);
    preload(12'hFFE, 8'hAA); preload(12'hFFF, 8'hBB); preload(12'h000, 8'hCC); preload(12'h001, 8'hDD);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_valids", {30'd0, inst_available_o, dm_valid_o}, 32'd0);
    check("rst_inst_o", inst_o, 32'd0);
    check("rst_dm_rdata", dm_rdata_o, 32'd0);
    rst = 1'b0;
    tick();

    // Word fetch from 0x100.
    inst_needed = 1'b1; inst_addr_i = 32'h0000_0100; inst_q.push_back(32'h0050_0513);
    tick(); acc = cyc;
    check("f_a0", mem_a, 32'h100); check("f_wr0", {31'd0, mem_wr}, 32'd0);
    tick(); check("f_a1", mem_a, 32'h101);
    tick(); check("f_a2", mem_a, 32'h102);
    tick(); check("f_a3", mem_a, 32'h103);
    wait_valid(1'b1, 10); inst_needed = 1'b0;
    check("f_latency", inst_cyc - acc, 32'd5);
    repeat (3) tick();
    check("f_once", inst_cnt, 32'd1);

    // Misaligned half store to 0x201.
    dm_req = 1'b1; dm_we = 1'b1; dm_width = 2'd1; dm_addr = 32'h201; dm_wdata = 32'hAABB_CCDD;
    dm_q.push_back({1'b0, 32'h0});
    tick(); check("sh_wr0", {31'd0, mem_wr}, 32'd1); check("sh_a0", mem_a, 32'h201); check("sh_d0", {24'd0, mem_dout}, 32'hDD);
    tick(); check("sh_wr1", {31'd0, mem_wr}, 32'd1); check("sh_a1", mem_a, 32'h202); check("sh_d1", {24'd0, mem_dout}, 32'hCC);
    wait_valid(1'b0, 10); dm_req = 1'b0;
    check("sh_wr_done", {31'd0, mem_wr}, 32'd0);
    tick();
    check("sh_ram201", {24'd0, ram[12'h201]}, 32'hDD);
    check("sh_ram202", {24'd0, ram[12'h202]}, 32'hCC);
    check("sh_ram203", {24'd0, ram[12'h203]}, 32'h77);

    // Byte load of 0x202, then width code 3 (word) load of 0x201.
    dm_req = 1'b1; dm_we = 1'b0; dm_width = 2'd0; dm_addr = 32'h202; dm_q.push_back({1'b1, 32'h0000_00CC});
    tick(); acc = cyc;
    wait_valid(1'b0, 10); dm_req = 1'b0;
    check("lb_latency", dm_cyc - acc, 32'd2);
    tick();
    dm_req = 1'b1; dm_width = 2'd3; dm_addr = 32'h201; dm_q.push_back({1'b1, 32'h9977_CCDD});
    tick(); acc = cyc;
    wait_valid(1'b0, 10); dm_req = 1'b0;
    check("lw_latency", dm_cyc - acc, 32'd5);
    check("inst_o_held", inst_o, 32'h0050_0513);
    tick();

    // Simultaneous requests: data first, fetch after DONE and one IDLE cycle.
    dm_req = 1'b1; dm_we = 1'b0; dm_width = 2'd0; dm_addr = 32'h100; dm_q.push_back({1'b1, 32'h0000_0013});
    inst_needed = 1'b1; inst_addr_i = 32'h100; inst_q.push_back(32'h0050_0513);
    tick(); check("arb_a0", mem_a, 32'h100);
    wait_valid(1'b0, 10); dm_req = 1'b0;
    check("arb_no_inst", inst_cnt, 32'd1);
    tick(); check("arb_idle_a", mem_a, 32'd0);
    tick(); check("arb_fetch_a", mem_a, 32'h100); acc = cyc;
    wait_valid(1'b1, 10); inst_needed = 1'b0;
    check("arb_f_latency", inst_cyc - acc, 32'd5);
    repeat (2) tick();
    check("arb_dm_cnt", dm_cnt, 32'd4);
    check("arb_inst_cnt", inst_cnt, 32'd2);

    // Reset when the word store would start byte 2.
    dm_req = 1'b1; dm_we = 1'b1; dm_width = 2'd2; dm_addr = 32'h300; dm_wdata = 32'h4433_2211;
    tick(); check("rs_a0", mem_a, 32'h300); check("rs_d0", {24'd0, mem_dout}, 32'h11);
    tick(); check("rs_a1", mem_a, 32'h301);
    rst = 1'b1;
    tick();
    check("rs_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rs_mem_a", mem_a, 32'd0);
    check("rs_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rs_inst_o", inst_o, 32'd0);
    check("rs_dm_rdata", dm_rdata_o, 32'd0);
    rst = 1'b0; dm_req = 1'b0;
    repeat (6) tick();
    check("rs_no_valid", dm_cnt, 32'd4);
    check("rs_ram300", {24'd0, ram[12'h300]}, 32'h11);
    check("rs_ram301", {24'd0, ram[12'h301]}, 32'h22);
    check("rs_ram302", {24'd0, ram[12'h302]}, 32'h00);
    check("rs_ram303", {24'd0, ram[12'h303]}, 32'h00);

    // Wrapping fetch at 0xFFFFFFFE, request held so a second fetch follows.
    inst_needed = 1'b1; inst_addr_i = 32'hFFFF_FFFE;
    inst_q.push_back(32'hDDCC_BBAA); inst_q.push_back(32'hDDCC_BBAA);
    tick(); check("wr_a0", mem_a, 32'hFFFF_FFFE);
    tick(); check("wr_a1", mem_a, 32'hFFFF_FFFF);
    tick(); check("wr_a2", mem_a, 32'h0000_0000);
    tick(); check("wr_a3", mem_a, 32'h0000_0001);
    wait_valid(1'b1, 10);
    tick(); check("hold_idle_a", mem_a, 32'd0);
    tick(); check("hold_accept_a", mem_a, 32'hFFFF_FFFE);
    wait_valid(1'b1, 10); inst_needed = 1'b0;
    repeat (3) tick();
    check("hold_inst_cnt", inst_cnt, 32'd4);
    check("hold_q_empty", inst_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller between the instruction cache / MEM stage and the single byte-wide unified RAM.
- Serialises 32-bit instruction fetches and byte/half/word data loads/stores into little-endian byte accesses.
- Arbitrates the two clients with data priority.
- Returns each result with a one-cycle valid pulse.

Parameters:
ADDR_WIDTH, 32, width of all address ports; byte offsets wrap modulo 2^ADDR_WIDTH.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
inst_needed  input  1  icache fetch request; held until inst_available_o
inst_addr_i  input  ADDR_WIDTH  fetch address
inst_available_o  output  1  one-cycle pulse: inst_o valid
inst_o  output  32  fetched word, little-endian
dm_req  input  1  MEM-stage request; held until dm_valid_o
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_WIDTH  data address; misalignment allowed
dm_width  input  2  0 = byte, 1 = half, 2 = word, 3 treated as word
dm_wdata  input  32  store data; low bytes used
dm_valid_o  output  1  one-cycle pulse: access complete
dm_rdata_o  output  32  load data, zero-extended; MEM stage sign-extends
mem_din  input  8  RAM read byte, valid the cycle after its address
mem_dout  output  8  RAM write byte
mem_a  output  ADDR_WIDTH  RAM byte address
mem_wr  output  1  RAM write enable; byte written at clock edge

Behaviour:
- States: IDLE, XFER, DONE.
- Reset, from any state including mid-transfer: next cycle in IDLE.
  - All outputs 0: mem_wr, mem_a, mem_dout, both valids, inst_o, dm_rdata_o.
  - Byte counter 0.
  - Bytes already written stay in RAM.
- IDLE: N = byte count (1/2/4; instruction fetch always 4). On a clock edge:
  - dm_req=1: accept data request, latch dm_we/dm_addr/dm_width/dm_wdata.
  - else inst_needed=1: accept fetch, latch inst_addr_i.
  - Accepted request goes to XFER with count=0.
  - Both requests high: data wins; fetch waits.
- Requests are never aborted. A data request arriving during a fetch waits for IDLE.
- Latched values are used throughout the transfer; input changes after acceptance are ignored.
- XFER, read:
  - Cycle k (k = 0..N-1) drives mem_a = base+k, mem_wr=0.
  - Byte k is captured from mem_din in cycle k+1 into bits [8k+7:8k].
  - After byte N-1 is captured, go to DONE.
  - Read cycles after acceptance edge: word 5, half 3, byte 2.
- XFER, write:
  - Cycle k drives mem_a = base+k, mem_wr=1, mem_dout = wdata[8k+7:8k].
  - After k = N-1, go to DONE.
- DONE (one cycle):
  - Pulse exactly one valid: inst_available_o for fetches, dm_valid_o for data.
  - Result register updated and held until the next completion of the same client. Upper bytes are 0 for sub-word loads.
  - mem_wr=0. Next state IDLE.
  - No request is accepted in DONE. At least one IDLE cycle separates transfers, so a client that deasserts combinationally on valid is not re-served.
- Outside write cycles: mem_wr=0. mem_a=0 in IDLE/DONE.
- Address increment wraps: base 0xFFFFFFFF, k=1 gives mem_a=0x00000000.

Decomposition:
- Add to defines.v:
  - `RamBus 7:0.
  - `MemWidthBus 1:0.
  - Width codes `MemByte 2'b00, `MemHalf 2'b01, `MemWord 2'b10.
  - State encodings `MemIdle, `MemXfer, `MemDone.
- Reuse `InstAddrBus and `InstBus.
- No sub-module: one FSM with a 3-bit byte counter and a 32-bit shift/assembly register.

Test Plan:
- Fetch: RAM[0x100..0x103] = 13,05,50,00; inst_needed=1 with addr 0x100 → mem_a 0x100..0x103 in consecutive cycles; inst_available_o pulses once, 5 cycles after acceptance; inst_o = 0x00500513.
- Store half: dm_we=1, width=1, addr 0x201, wdata 0xAABBCCDD → mem_wr high two cycles, bytes DD@0x201 and CC@0x202; dm_valid_o pulses once; later byte load of 0x202 returns 0x000000CC.
- Arbitration: dm_req (byte load) and inst_needed rise in the same cycle → data served first; fetch accepted only after the DONE and IDLE cycles; each valid pulses once.
- Mid-transfer reset: rst asserted during word store byte 2 → next cycle mem_wr=0, state IDLE, no valid; RAM holds bytes 0–1 only.
- Wrap: word fetch at 0xFFFFFFFE → mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Held request: inst_needed kept high after the pulse → second fetch accepted in the IDLE cycle after DONE, never in DONE.
